// File: rtl/crossbar_nxn_arb.sv
// N x N crossbar with one holding register per output and a round-robin arbiter per output.
// Each input transfers when it wins arbitration for its destination and that output can accept.
module crossbar_nxn_arb #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4,
    localparam int unsigned S = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N*S-1:0] in_dest,
    output logic [N-1:0]   in_ready,
    output logic [N-1:0]   out_valid,
    output logic [N*W-1:0] out_data,
    output logic [N*S-1:0] out_src,
    input  logic [N-1:0]   out_ready
);

    logic [W-1:0] in_word [N];
    logic [S-1:0] in_idx  [N];
    logic [W-1:0] data_q  [N];
    logic [S-1:0] src_q   [N];
    logic [S-1:0] ptr_q   [N];
    logic [N-1:0] valid_q;

    logic [N-1:0] req     [N];
    logic [N-1:0] gnt_vld;
    logic [S-1:0] gnt_idx [N];
    logic [N-1:0] can_accept;
    logic [N-1:0] load;
    logic [S-1:0] cand;

    for (genvar g = 0; g < N; g++) begin : g_port
        assign in_word[g]         = in_data[g*W +: W];
        assign in_idx[g]          = in_dest[g*S +: S];
        assign out_data[g*W +: W] = data_q[g];
        assign out_src[g*S +: S]  = src_q[g];
    end

    assign out_valid = valid_q;

    // req[j][i]: input i is presenting a word for output j
    always_comb begin
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                req[j][i] = in_valid[i] && (in_idx[i] == S'(j));
            end
        end
    end

    // Scan from ptr upward; S-bit addition wraps modulo N because N is a power of two.
    always_comb begin
        cand       = '0;
        gnt_vld    = '0;
        can_accept = '0;
        load       = '0;
        for (int j = 0; j < N; j++) begin
            gnt_idx[j] = '0;
            for (int k = 0; k < N; k++) begin
                cand = ptr_q[j] + S'(k);
                if (!gnt_vld[j] && req[j][cand]) begin
                    gnt_vld[j] = 1'b1;
                    gnt_idx[j] = cand;
                end
            end
            can_accept[j] = !valid_q[j] || out_ready[j];
            load[j]       = !rst && gnt_vld[j] && can_accept[j];
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = in_valid[i] && load[in_idx[i]] && (gnt_idx[in_idx[i]] == S'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int j = 0; j < N; j++) begin
                data_q[j] <= '0;
                src_q[j]  <= '0;
                ptr_q[j]  <= '0;
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                if (load[j]) begin
                    valid_q[j] <= 1'b1;
                    data_q[j]  <= in_word[gnt_idx[j]];
                    src_q[j]   <= gnt_idx[j];
                    ptr_q[j]   <= gnt_idx[j] + S'(1);
                end else if (out_ready[j]) begin
                    valid_q[j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_crossbar_nxn_arb.sv
// Directed checks of crossbar_nxn_arb (N=4, W=4) followed by a randomized scoreboard run.
module tb_crossbar_nxn_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [7:0]  in_dest;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_src;
    logic [3:0]  out_ready;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q [16][$];
    int         seq   [4];
    int         acc_n = 0;
    int         del_n = 0;
    int         pend;
    logic [3:0] rdy_snap;

    crossbar_nxn_arb #(.N(4), .W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops the expected word for every output transfer happening at the coming edge.
    task automatic score_outputs;
        int k;
        logic [3:0] e;
        for (int j = 0; j < 4; j++) begin
            if (out_valid[j] && out_ready[j]) begin
                k = int'(out_src[j*2 +: 2]) * 4 + j;
                chk("sb_known_word", 32'(exp_q[k].size() > 0), 32'd1);
                if (exp_q[k].size() > 0) begin
                    e = exp_q[k].pop_front();
                    chk("sb_data", 32'(out_data[j*4 +: 4]), 32'(e));
                end
                del_n++;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        in_dest   = '0;
        out_ready = 4'hF;
        tick;
        tick;

        // Transfer presented during reset must be refused and discarded
        in_valid = 4'hF;
        in_data  = 16'hDCBA;
        in_dest  = 8'h1B;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        tick;
        rst      = 1'b0;
        in_valid = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_src", 32'(out_src), 32'h0);

        // Permutation: all four inputs to distinct outputs in one cycle
        in_valid = 4'hF;
        #1;
        chk("perm_in_ready", 32'(in_ready), 32'hF);
        tick;
        in_valid = '0;
        #1;
        chk("perm_out_valid", 32'(out_valid), 32'hF);
        chk("perm_out_data", 32'(out_data), 32'hABCD);
        chk("perm_out_src", 32'(out_src), 32'h1B);
        tick;
        chk("idle_drain", 32'(out_valid), 32'h0);

        rst = 1'b1;
        tick;
        rst = 1'b0;

        // Contention on output 1: grants rotate 0,1,2,3,0,1
        in_valid = 4'hF;
        in_data  = 16'h4321;
        in_dest  = 8'h55;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("cont_in_ready", 32'(in_ready), 32'h1 << (c % 4));
            tick;
            chk("cont_out_data", 32'(out_data[7:4]), 32'((c % 4) + 1));
            chk("cont_out_src", 32'(out_src[3:2]), 32'(c % 4));
        end

        // Mid-operation reset with ptr[1]=2 and output 1 stalled
        out_ready = 4'h0;
        rst       = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
        tick;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("post_rst_grant", 32'(in_ready), 32'h1);
        tick;
        chk("post_rst_src", 32'(out_src[3:2]), 32'h0);
        in_valid  = '0;
        out_ready = 4'hF;
        tick;

        // Backpressure on output 2
        out_ready = 4'b1011;
        in_valid  = 4'b0001;
        in_data   = 16'h0005;
        in_dest   = 8'h02;
        #1;
        chk("bp_first_ready", 32'(in_ready), 32'h1);
        tick;
        in_data = 16'h0006;
        #1;
        chk("bp_blocked", 32'(in_ready), 32'h0);
        chk("bp_out_valid", 32'(out_valid[2]), 32'h1);
        chk("bp_hold_data", 32'(out_data[11:8]), 32'h5);
        tick;
        chk("bp_still_blocked", 32'(in_ready), 32'h0);
        chk("bp_stable_data", 32'(out_data[11:8]), 32'h5);
        out_ready = 4'hF;
        #1;
        chk("bp_release", 32'(in_ready), 32'h1);
        tick;
        in_valid = '0;
        #1;
        chk("bp_second_data", 32'(out_data[11:8]), 32'h6);
        chk("bp_second_valid", 32'(out_valid[2]), 32'h1);
        tick;

        // Load-and-drain on output 0
        in_valid = 4'b0010;
        in_data  = 16'h0070;
        in_dest  = 8'h00;
        #1;
        chk("ld_first_ready", 32'(in_ready), 32'h2);
        tick;
        in_valid = 4'b0100;
        in_data  = 16'h0800;
        #1;
        chk("ld_second_ready", 32'(in_ready), 32'h4);
        chk("ld_first_held", 32'(out_data[3:0]), 32'h7);
        tick;
        in_valid = '0;
        #1;
        chk("ld_no_bubble", 32'(out_valid[0]), 32'h1);
        chk("ld_new_data", 32'(out_data[3:0]), 32'h8);
        chk("ld_new_src", 32'(out_src[1:0]), 32'h2);
        tick;
        chk("ld_idle_clear", 32'(out_valid), 32'h0);

        // Randomized scoreboard
        for (int i = 0; i < 4; i++) seq[i] = 0;
        for (int c = 0; c < 1000; c++) begin
            for (int j = 0; j < 4; j++) out_ready[j] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!in_valid[i] && $urandom_range(0, 9) < 6) begin
                    in_valid[i]       = 1'b1;
                    in_data[i*4 +: 4] = 4'(seq[i]);
                    in_dest[i*2 +: 2] = 2'($urandom_range(0, 3));
                    seq[i]++;
                end
            end
            #1;
            score_outputs();
            for (int i = 0; i < 4; i++) begin
                if (in_ready[i]) begin
                    chk("sb_ready_needs_valid", 32'(in_valid[i]), 32'h1);
                    exp_q[i*4 + int'(in_dest[i*2 +: 2])].push_back(in_data[i*4 +: 4]);
                    acc_n++;
                end
            end
            rdy_snap = in_ready;
            tick;
            for (int i = 0; i < 4; i++) if (rdy_snap[i]) in_valid[i] = 1'b0;
        end
        in_valid  = '0;
        out_ready = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #1;
            score_outputs();
            tick;
        end
        pend = 0;
        for (int k = 0; k < 16; k++) pend += exp_q[k].size();
        chk("sb_nothing_pending", 32'(pend), 32'h0);
        chk("sb_counts_match", 32'(del_n), 32'(acc_n));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
